// File: rtl/flog_in_stage.sv
// rtl/flog_in_stage.sv - bfloat16 log2 input front-end: operand FIFO, special-case bypass, core issue; optional stats via FLOG_IN_STATS_EN
package flog_pkg;
  parameter int EXP_WIDTH = 8;
  parameter int MAN_WIDTH = 7;
  parameter int OP_WIDTH  = 1 + EXP_WIDTH + MAN_WIDTH;
endpackage

// Operand queue: registered ready, head visible combinationally.
module flog_in_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wr_tdata,
  input  logic          wr_tvalid,
  output logic          wr_tready,
  output logic [DW-1:0] rd_tdata,
  output logic          rd_tvalid,
  input  logic          rd_pop
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          push, pop;

  // Pointer/count update; ready is taken from the next count so it is !full in every cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = wr_tvalid && ready_q;
    pop      = rd_pop && (count_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = wr_tdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    ready_d = (count_d != CW'(DEPTH));
  end

  // Queue state registers; ready is low while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign wr_tready = ready_q;
  assign rd_tdata  = mem_q[rd_ptr_q];
  assign rd_tvalid = (count_q != '0);
endmodule

module flog_in_stage
  import flog_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_WIDTH-1:0]  in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 sign_o,
  output logic [EXP_WIDTH-1:0] exp_o,
  output logic [MAN_WIDTH-1:0] frac_o,
  output logic                 core_valid_o,
  input  logic                 core_done_i,
  output logic                 byp_valid_o,
  output logic [OP_WIDTH-1:0]  byp_res_o,
  output logic                 busy_o
`ifdef FLOG_IN_STATS_EN
  ,
  output logic [15:0]          byp_cnt_o,
  output logic [15:0]          issue_cnt_o
`endif
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_BYPASS} state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  core_valid_q, core_valid_d;
  logic                  byp_valid_q, byp_valid_d;
  logic                  sign_q, sign_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [MAN_WIDTH-1:0]  frac_q, frac_d;
  logic [OP_WIDTH-1:0]   byp_res_q, byp_res_d;

  logic                  fifo_ready;
  logic                  head_valid;
  logic [OP_WIDTH-1:0]   head;
  logic                  pop;
  logic                  head_s;
  logic [EXP_WIDTH-1:0]  head_e;
  logic [MAN_WIDTH-1:0]  head_f;
  logic                  head_normal;
  logic [OP_WIDTH-1:0]   special_res;
  logic                  can_issue;
  logic                  done_eff;

  flog_in_fifo #(
    .DW    (OP_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_tdata  (in_data_i),
    .wr_tvalid (in_valid_i),
    .wr_tready (fifo_ready),
    .rd_tdata  (head),
    .rd_tvalid (head_valid),
    .rd_pop    (pop)
  );

  assign {head_s, head_e, head_f} = head;
  assign head_normal = !head_s && (head_e != '0) && (head_e != '1);
  assign can_issue   = (outst_q < OW'(MAX_OUTSTANDING));
  // A done with nothing outstanding is stray and must not underflow the count.
  assign done_eff    = core_done_i && (outst_q != '0);

  // Local result for non-normal heads: zero/denormal -> -inf, +inf -> +inf, everything else -> qNaN.
  always_comb begin
    special_res = 16'h7FC0;
    if (head_e == '0) begin
      special_res = 16'hFF80;
    end else if ((head_e == '1) && (head_f == '0) && !head_s) begin
      special_res = 16'h7F80;
    end
  end

  // Outstanding core operations: issue pulse adds one, effective done removes one.
  always_comb begin
    outst_d = outst_q;
    if (core_valid_q && !done_eff) begin
      outst_d = outst_q + OW'(1);
    end else if (!core_valid_q && done_eff) begin
      outst_d = outst_q - OW'(1);
    end
  end

  // Issue/bypass sequencing; a bypass waits for all earlier core results to keep order.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    core_valid_d = 1'b0;
    byp_valid_d  = 1'b0;
    sign_d       = sign_q;
    exp_d        = exp_q;
    frac_d       = frac_q;
    byp_res_d    = byp_res_q;
    case (state_q)
      S_IDLE: begin
        if (head_valid) begin
          state_d = head_normal ? S_ISSUE : S_DRAIN;
        end
      end
      S_ISSUE: begin
        if (can_issue) begin
          pop          = 1'b1;
          sign_d       = head_s;
          exp_d        = head_e;
          frac_d       = head_f;
          core_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_DRAIN: begin
        if ((outst_q == '0) || ((outst_q == OW'(1)) && core_done_i)) begin
          state_d = S_BYPASS;
        end
      end
      S_BYPASS: begin
        pop         = 1'b1;
        byp_res_d   = special_res;
        byp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      outst_q      <= '0;
      core_valid_q <= 1'b0;
      byp_valid_q  <= 1'b0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      frac_q       <= '0;
      byp_res_q    <= '0;
    end else begin
      state_q      <= state_d;
      outst_q      <= outst_d;
      core_valid_q <= core_valid_d;
      byp_valid_q  <= byp_valid_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      frac_q       <= frac_d;
      byp_res_q    <= byp_res_d;
    end
  end

  assign in_ready_o   = fifo_ready;
  assign sign_o       = sign_q;
  assign exp_o        = exp_q;
  assign frac_o       = frac_q;
  assign core_valid_o = core_valid_q;
  assign byp_valid_o  = byp_valid_q;
  assign byp_res_o    = byp_res_q;
  assign busy_o       = head_valid || (outst_q != '0);

`ifdef FLOG_IN_STATS_EN
  logic [15:0] byp_cnt_q, byp_cnt_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;

  // Saturating pulse counters.
  always_comb begin
    byp_cnt_d   = byp_cnt_q;
    issue_cnt_d = issue_cnt_q;
    if (byp_valid_q && (byp_cnt_q != 16'hFFFF)) begin
      byp_cnt_d = byp_cnt_q + 16'd1;
    end
    if (core_valid_q && (issue_cnt_q != 16'hFFFF)) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_cnt_q   <= '0;
      issue_cnt_q <= '0;
    end else begin
      byp_cnt_q   <= byp_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign byp_cnt_o   = byp_cnt_q;
  assign issue_cnt_o = issue_cnt_q;
`endif
endmodule

// File: tb/tb_flog_in_stage.sv
// tb/tb_flog_in_stage.sv - self-checking bench for flog_in_stage
module tb_flog_in_stage;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        sign_o;
  logic [7:0]  exp_o;
  logic [6:0]  frac_o;
  logic        core_valid_o;
  logic        core_done_i;
  logic        byp_valid_o;
  logic [15:0] byp_res_o;
  logic        busy_o;
`ifdef FLOG_IN_STATS_EN
  logic [15:0] byp_cnt_o;
  logic [15:0] issue_cnt_o;
`endif

  flog_in_stage #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(MAXO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .sign_o       (sign_o),
    .exp_o        (exp_o),
    .frac_o       (frac_o),
    .core_valid_o (core_valid_o),
    .core_done_i  (core_done_i),
    .byp_valid_o  (byp_valid_o),
    .byp_res_o    (byp_res_o),
    .busy_o       (busy_o)
`ifdef FLOG_IN_STATS_EN
    ,
    .byp_cnt_o    (byp_cnt_o),
    .issue_cnt_o  (issue_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  int          pend[$];
  logic [15:0] byp_log[$];
  int          bo = 0;
  int          n_core = 0;
  int          n_byp = 0;
  int          n_acc = 0;
  bit          auto_done = 1'b0;
  bit          last_acc, last_core, last_byp;

  logic [15:0] spec_in  [7] = '{16'h0000, 16'h8000, 16'h0011, 16'h7F80, 16'hFF80, 16'h7FC1, 16'hBF80};
  logic [15:0] spec_exp [7] = '{16'hFF80, 16'hFF80, 16'hFF80, 16'h7F80, 16'h7FC0, 16'h7FC0, 16'h7FC0};

  function automatic bit is_normal(logic [15:0] op);
    return !op[15] && (op[14:7] != 8'h00) && (op[14:7] != 8'hFF);
  endfunction

  function automatic logic [15:0] ref_res(logic [15:0] op);
    if (op[14:7] == 8'h00) return 16'hFF80;
    if (op[14:7] == 8'hFF && op[6:0] != 7'd0) return 16'h7FC0;
    if (op[15]) return 16'h7FC0;
    if (op[14:7] == 8'hFF) return 16'h7F80;
    return 16'h0000;
  endfunction

  function automatic logic [15:0] rand_normal();
    logic [7:0] e;
    logic [6:0] f;
    e = 8'($urandom_range(1, 254));
    f = 7'($urandom);
    return {1'b0, e, f};
  endfunction

  function automatic logic [15:0] rand_op();
    logic       s;
    logic [7:0] e;
    logic [6:0] f;
    s = 1'($urandom);
    e = 8'($urandom_range(1, 254));
    f = 7'($urandom);
    case ($urandom_range(0, 5))
      0:       return {s, 8'h00, f};
      1:       return {s, 8'hFF, 7'd0};
      2:       return {s, 8'hFF, f | 7'd1};
      3:       return {1'b1, e, f};
      default: return {1'b0, e, f};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: accept bookkeeping, output monitor against the in-order model, core responder.
  task automatic tick();
    bit          acc, dn;
    logic [15:0] d, op;
    acc = in_valid_i && in_ready_o;
    dn  = core_done_i;
    d   = in_data_i;
    @(posedge clk);
    #1;
    last_acc  = acc;
    last_core = core_valid_o;
    last_byp  = byp_valid_o;
    if (acc) exp_q.push_back(d);
    if (dn && bo > 0) bo--;
    if (core_valid_o) begin
      n_core++;
      check("core_cap", bo < MAXO, 1);
      check("core_has_op", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        op = exp_q.pop_front();
        check("core_op", {is_normal(op), sign_o, exp_o, frac_o}, {1'b1, op});
      end
      bo++;
      if (auto_done) pend.push_back($urandom_range(2, 6));
    end
    if (byp_valid_o) begin
      n_byp++;
      byp_log.push_back(byp_res_o);
      check("byp_after_core", bo, 0);
      check("byp_has_op", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        op = exp_q.pop_front();
        check("byp_res", {is_normal(op), byp_res_o}, {1'b0, ref_res(op)});
      end
    end
    if (auto_done) begin
      core_done_i = 1'b0;
      foreach (pend[i]) pend[i]--;
      if (pend.size() != 0 && pend[0] <= 0) begin
        core_done_i = 1'b1;
        void'(pend.pop_front());
      end
    end
  endtask

  task automatic push_op(logic [15:0] d);
    int k = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    do begin
      tick();
      k++;
    end while (!last_acc && k < 50);
    in_valid_i = 1'b0;
    check("push_accept", last_acc, 1);
  endtask

  task automatic wait_core(string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!last_core && k < 30);
    check(tag, last_core, 1);
  endtask

  task automatic drain(string tag);
    int k = 0;
    while ((busy_o || exp_q.size() != 0 || pend.size() != 0 || core_done_i) && k < 400) begin
      tick();
      k++;
    end
    check(tag, k < 400, 1);
  endtask

  task automatic bp_tick();
    tick();
    if (last_acc) begin
      n_acc++;
      if (n_acc < 10) in_data_i = rand_normal();
      else in_valid_i = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc0, nb0, k;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    core_done_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pulses", {core_valid_o, byp_valid_o}, 0);
    check("rst_fields", {sign_o, exp_o, frac_o}, 0);
    check("rst_byp_res", byp_res_o, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", in_ready_o, 1);

    // Normal operand latency and field values
    in_valid_i = 1'b1;
    in_data_i  = 16'h72AD;
    tick();
    in_valid_i = 1'b0;
    check("lat_accept", last_acc, 1);
    check("lat_c1", core_valid_o, 0);
    tick();
    check("lat_c2", core_valid_o, 0);
    tick();
    check("lat_c3", core_valid_o, 1);
    check("lat_fields", {sign_o, exp_o, frac_o}, 16'h72AD);
    tick();
    check("lat_pulse_width", core_valid_o, 0);
    check("lat_fields_hold", {sign_o, exp_o, frac_o}, 16'h72AD);
    check("lat_busy", busy_o, 1);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    check("lat_busy_drop", busy_o, 0);

    // Special operands resolved locally, in order
    auto_done = 1'b1;
    nc0 = n_core;
    byp_log.delete();
    foreach (spec_in[i]) push_op(spec_in[i]);
    drain("spec_drain");
    check("spec_no_core", n_core - nc0, 0);
    check("spec_count", byp_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < byp_log.size()) check($sformatf("spec_res%0d", i), byp_log[i], spec_exp[i]);
    end
    repeat (3) tick();
    check("byp_res_hold", byp_res_o, 16'h7FC0);

    // Ordering: bypass waits behind an outstanding core result
    auto_done = 1'b0;
    nb0 = n_byp;
    push_op(16'h3F80);
    push_op(16'h0000);
    repeat (10) tick();
    check("order_hold", n_byp - nb0, 0);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    k = 0;
    while (!last_byp && k < 10) begin
      tick();
      k++;
    end
    check("order_byp", last_byp, 1);
    check("order_res", byp_res_o, 16'hFF80);
    drain("order_drain");

    // Backpressure: outstanding cap and FIFO full
    n_acc = 0;
    nc0 = n_core;
    in_valid_i = 1'b1;
    in_data_i  = rand_normal();
    repeat (40) bp_tick();
    check("bp_accepts", n_acc, 8);
    check("bp_issues", n_core - nc0, 4);
    check("bp_ready_low", in_ready_o, 0);
    check("bp_busy", busy_o, 1);
    core_done_i = 1'b1;
    bp_tick();
    core_done_i = 1'b0;
    repeat (6) bp_tick();
    check("bp_release_issue", n_core - nc0, 5);
    check("bp_release_accept", n_acc, 9);
    auto_done = 1'b1;
    for (int i = 0; i < bo; i++) pend.push_back(2 + i);
    k = 0;
    while (n_acc < 10 && k < 100) begin
      bp_tick();
      k++;
    end
    check("bp_all_accepted", n_acc, 10);
    drain("bp_drain");

    // Spurious done at zero, simultaneous issue and done
    auto_done = 1'b0;
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    tick();
    check("spurious_busy", busy_o, 0);
    push_op(rand_normal());
    wait_core("sim_a_issue");
    push_op(rand_normal());
    wait_core("sim_b_issue");
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    repeat (3) tick();
    check("sim_busy_kept", busy_o, 1);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    check("sim_busy_clear", busy_o, 0);

    // Reset mid-stream: 2 outstanding, 3 queued specials
    push_op(rand_normal());
    push_op(rand_normal());
    push_op(16'h0000);
    push_op(16'h7F80);
    push_op(16'h7FC1);
    repeat (6) tick();
    check("mid_busy_before", busy_o, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", in_ready_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_pulses", {core_valid_o, byp_valid_o}, 0);
    check("mid_rst_fields", {sign_o, exp_o, frac_o}, 0);
    check("mid_rst_byp_res", byp_res_o, 0);
    exp_q.delete();
    pend.delete();
    bo = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("mid_ready_after", in_ready_o, 1);
    check("mid_busy_after", busy_o, 0);
    nb0 = n_byp;
    nc0 = n_core;
    repeat (10) tick();
    check("mid_no_stale", (n_byp - nb0) + (n_core - nc0), 0);

    // Randomized mixed stream against the in-order model
    auto_done = 1'b1;
    nb0 = n_byp;
    nc0 = n_core;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push_op(rand_op());
    end
    drain("rand_drain");
    check("rand_resolved", (n_byp - nb0) + (n_core - nc0), 40);
    check("rand_model_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
